// File: rtl/seven_segment_display.sv
// Registered 4-bit to 7-segment decoder for one digit; outputs are a..g plus the decimal point.
// Define SSD_HEX_EN to decode 10..15 as A b C d E F; otherwise they blank and light the dot.
module seven_segment_display #(
   parameter bit ACTIVE_LOW_SEG = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ina,
   input  logic inb,
   input  logic inc,
   input  logic ind,
   output logic outa,
   output logic outb,
   output logic outc,
   output logic outd,
   output logic oute,
   output logic outf,
   output logic outg,
   output logic outseg
);

   localparam logic [7:0] POL = {8{ACTIVE_LOW_SEG}};

   logic [3:0] nib_p1;
   logic [7:0] seg_p2;

   // Bit order {a,b,c,d,e,f,g,dp}, 1 = lit.
   function automatic logic [7:0] decode(input logic [3:0] n);
      logic [7:0] s;
      case (n)
         4'd0:    s = 8'b1111110_0;
         4'd1:    s = 8'b0110000_0;
         4'd2:    s = 8'b1101101_0;
         4'd3:    s = 8'b1111001_0;
         4'd4:    s = 8'b0110011_0;
         4'd5:    s = 8'b1011011_0;
         4'd6:    s = 8'b1011111_0;
         4'd7:    s = 8'b1110000_0;
         4'd8:    s = 8'b1111111_0;
         4'd9:    s = 8'b1111011_0;
`ifdef SSD_HEX_EN
         4'd10:   s = 8'b1110111_0;
         4'd11:   s = 8'b0011111_0;
         4'd12:   s = 8'b1001110_0;
         4'd13:   s = 8'b0111101_0;
         4'd14:   s = 8'b1001111_0;
         default: s = 8'b1000111_0;
`else
         default: s = 8'b0000000_1;
`endif
      endcase
      return s;
   endfunction

   // Stage 1: resample the asynchronous nibble; stage 2: decoded, polarity-adjusted segments.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nib_p1 <= 4'd0;
         seg_p2 <= POL;
      end else begin
         nib_p1 <= {ina, inb, inc, ind};
         seg_p2 <= decode(nib_p1) ^ POL;
      end
   end

   assign outa   = seg_p2[7];
   assign outb   = seg_p2[6];
   assign outc   = seg_p2[5];
   assign outd   = seg_p2[4];
   assign oute   = seg_p2[3];
   assign outf   = seg_p2[2];
   assign outg   = seg_p2[1];
   assign outseg = seg_p2[0];

endmodule

// File: tb/tb_seven_segment_display.sv
// Bench for seven_segment_display: reset, full sweep, latency, polarity, mid-run reset and
// randomized nibbles against a table-driven reference model. Honours SSD_HEX_EN.
module tb_seven_segment_display;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic ina = 1'b0, inb = 1'b0, inc = 1'b0, ind = 1'b0;
   logic a0, b0, c0, d0, e0, f0, g0, dp0;
   logic a1, b1, c1, d1, e1, f1, g1, dp1;

   int checks = 0;
   int errors = 0;
   logic [6:0] glyph [16];
   logic [3:0] app [$];

   always #5 clk = ~clk;

   seven_segment_display #(.ACTIVE_LOW_SEG(1'b0)) dut_hi (
      .clk(clk), .rst_n(rst_n), .ina(ina), .inb(inb), .inc(inc), .ind(ind),
      .outa(a0), .outb(b0), .outc(c0), .outd(d0), .oute(e0), .outf(f0), .outg(g0),
      .outseg(dp0));

   seven_segment_display #(.ACTIVE_LOW_SEG(1'b1)) dut_lo (
      .clk(clk), .rst_n(rst_n), .ina(ina), .inb(inb), .inc(inc), .ind(ind),
      .outa(a1), .outb(b1), .outc(c1), .outd(d1), .oute(e1), .outf(f1), .outg(g1),
      .outseg(dp1));

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Reference: lit pattern {a..g,dp} for a nibble, complemented for the active-low part.
   function automatic logic [7:0] ref_seg(input int n, input bit al);
      logic [7:0] v;
      if (n < 10) v = {glyph[n], 1'b0};
`ifdef SSD_HEX_EN
      else v = {glyph[n], 1'b0};
`else
      else v = 8'b0000000_1;
`endif
      return al ? ~v : v;
   endfunction

   function automatic logic [7:0] ref_blank(input bit al);
      return al ? 8'hFF : 8'h00;
   endfunction

   task automatic set_nib(input logic [3:0] n);
      {ina, inb, inc, ind} = n;
   endtask

   task automatic check_both(input string tag, input logic [7:0] e_hi, input logic [7:0] e_lo);
      check({tag, "_hi"}, {a0, b0, c0, d0, e0, f0, g0, dp0}, e_hi);
      check({tag, "_lo"}, {a1, b1, c1, d1, e1, f1, g1, dp1}, e_lo);
   endtask

   task automatic check_nib(input string tag, input int n);
      check_both(tag, ref_seg(n, 1'b0), ref_seg(n, 1'b1));
   endtask

   task automatic check_blank(input string tag);
      check_both(tag, ref_blank(1'b0), ref_blank(1'b1));
   endtask

   initial begin
      glyph[0]  = 7'b1111110; glyph[1]  = 7'b0110000; glyph[2]  = 7'b1101101;
      glyph[3]  = 7'b1111001; glyph[4]  = 7'b0110011; glyph[5]  = 7'b1011011;
      glyph[6]  = 7'b1011111; glyph[7]  = 7'b1110000; glyph[8]  = 7'b1111111;
      glyph[9]  = 7'b1111011; glyph[10] = 7'b1110111; glyph[11] = 7'b0011111;
      glyph[12] = 7'b1001110; glyph[13] = 7'b0111101; glyph[14] = 7'b1001111;
      glyph[15] = 7'b1000111;

      // Reset with arbitrary inputs: outputs clear before any clock edge and stay clear.
      set_nib(4'($urandom_range(0, 15)));
      #2 rst_n = 1'b0;
      #1 check_blank("reset_async");
      repeat (3) @(negedge clk);
      set_nib(4'd8);
      check_blank("reset_hold");

      // Full sweep, one nibble per 50 ns, with a reset pulse while showing 5.
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 16; n++) begin
         set_nib(4'(n));
         repeat (2) @(negedge clk);
         check_nib($sformatf("sweep_%0d", n), n);
         if (n == 5) begin
            #2 rst_n = 1'b0;
            #1 check_blank("midrun_reset");
            @(negedge clk);
            check_blank("midrun_hold");
            rst_n = 1'b1;
            @(negedge clk);
            check_nib("midrun_edge1", 0);
            @(negedge clk);
            check_nib("midrun_edge2", 5);
         end
         repeat (3) @(negedge clk);
      end

      // Explicit 12 check for the active configuration.
      set_nib(4'd12);
      repeat (2) @(negedge clk);
`ifdef SSD_HEX_EN
      check_both("overflow_12", 8'b1001110_0, 8'b0110001_1);
`else
      check_both("overflow_12", 8'b0000000_1, 8'b1111111_0);
`endif

      // Polarity: nibble 1 on the active-low part.
      set_nib(4'd1);
      repeat (2) @(negedge clk);
      check_both("polarity_1", 8'b0110000_0, 8'b1001111_1);

      // Latency: 0 -> 8 one ns before an edge.
      set_nib(4'd0);
      repeat (3) @(negedge clk);
      #4 set_nib(4'd8);
      @(posedge clk); #1;
      check_nib("latency_edge1", 0);
      @(posedge clk); #1;
      check_nib("latency_edge2", 8);

      // Randomized run from a fresh reset; outputs after edge i reflect the nibble applied before edge i-1.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      app.delete();
      for (int i = 0; i < 300; i++) begin
         if (i == 0) check_blank("rand_edge0");
         else if (i == 1) check_nib("rand_edge1", 0);
         else check_nib($sformatf("rand_%0d", i), int'(app[i-2]));
         if (i == 0 || $urandom_range(0, 3) != 0) app.push_back(4'($urandom_range(0, 15)));
         else app.push_back(app[i-1]);
         set_nib(app[i]);
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
